// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for mem_port_arbiter: one-hot state encodings,
// owner encoding and the captured request type.
package mem_port_arbiter_pkg;

    localparam logic [5:0] ARB_IDLE   = 6'b000001;
    localparam logic [5:0] ARB_I_REQ  = 6'b000010;
    localparam logic [5:0] ARB_I_RESP = 6'b000100;
    localparam logic [5:0] ARB_D_RD   = 6'b001000;
    localparam logic [5:0] ARB_D_WR   = 6'b010000;
    localparam logic [5:0] ARB_D_RESP = 6'b100000;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    typedef enum logic [5:0] {
        S_IDLE   = ARB_IDLE,
        S_I_REQ  = ARB_I_REQ,
        S_I_RESP = ARB_I_RESP,
        S_D_RD   = ARB_D_RD,
        S_D_WR   = ARB_D_WR,
        S_D_RESP = ARB_D_RESP
    } arb_state_e;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_type_e;

endpackage

// File: rtl/arb_req_reg.sv
// Capture register for the granted request (addr/wdata/wstrb/type).
// Downstream request fields are driven only from here, so they stay
// stable while the memory side stalls.
module arb_req_reg
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  req_type_e           type_i,
    output logic [ADDR_W-1:0]   addr_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] wstrb_o,
    output req_type_e           type_o
);

    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    req_type_e           type_q,  type_d;

    // Hold the request unless a new grant loads it
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        type_d  = type_q;
        if (load) begin
            addr_d  = addr_i;
            wdata_d = wdata_i;
            wstrb_d = wstrb_i;
            type_d  = type_i;
        end
    end

    // Request register, cleared on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            type_q  <= REQ_READ;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            type_q  <= type_d;
        end
    end

    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
    assign wstrb_o = wstrb_q;
    assign type_o  = type_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction-fetch and data
// load/store channels. One transaction in flight; the response is
// steered combinationally to the granted side.
// Optional macro ARB_RR_EN: round-robin between fetch and data instead
// of fixed data-over-fetch priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    // fetch channel
    input  logic [ADDR_W-1:0]   PC,
    input  logic                Inst_Req_Valid,
    output logic                Inst_Req_Ready,
    output logic [DATA_W-1:0]   Instruction,
    output logic                Inst_Valid,
    input  logic                Inst_Ready,
    // data channel
    input  logic [ADDR_W-1:0]   Address,
    input  logic                MemWrite,
    input  logic [DATA_W-1:0]   Write_data,
    input  logic [DATA_W/8-1:0] Write_strb,
    input  logic                MemRead,
    output logic                Mem_Req_Ready,
    output logic [DATA_W-1:0]   Read_data,
    output logic                Read_data_Valid,
    input  logic                Read_data_Ready,
    // downstream memory port
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic                mem_wen,
    output logic                mem_ren,
    input  logic                mem_req_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_rdata_valid,
    output logic                mem_rdata_ready
);

    arb_state_e          state_q, state_d;
    logic                load;
    logic [ADDR_W-1:0]   ld_addr;
    logic [DATA_W-1:0]   ld_wdata;
    logic [DATA_W/8-1:0] ld_wstrb;
    req_type_e           ld_type;
    req_type_e           req_type;
    logic                grant_data;

`ifdef ARB_RR_EN
    logic last_owner_q, last_owner_d;

    // Data wins unless fetch is also waiting and data was served last
    always_comb begin
        grant_data = (MemRead | MemWrite) &
                     (~Inst_Req_Valid | (last_owner_q == OWN_INST));
    end

    // Remember which side was granted most recently
    always_ff @(posedge clk) begin
        if (rst) last_owner_q <= OWN_INST;
        else     last_owner_q <= last_owner_d;
    end
`else
    // Fixed priority: any data request beats a fetch
    always_comb begin
        grant_data = MemRead | MemWrite;
    end
`endif

    arb_req_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_req_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .addr_i  (ld_addr),
        .wdata_i (ld_wdata),
        .wstrb_i (ld_wstrb),
        .type_i  (ld_type),
        .addr_o  (mem_addr),
        .wdata_o (mem_wdata),
        .wstrb_o (mem_wstrb),
        .type_o  (req_type)
    );

    // State register; reset drops any in-flight transaction
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state, grant capture and request/response steering
    always_comb begin
        state_d         = state_q;
        load            = 1'b0;
        ld_addr         = '0;
        ld_wdata        = '0;
        ld_wstrb        = '0;
        ld_type         = REQ_READ;
        Inst_Req_Ready  = 1'b0;
        Mem_Req_Ready   = 1'b0;
        Instruction     = '0;
        Inst_Valid      = 1'b0;
        Read_data       = '0;
        Read_data_Valid = 1'b0;
        mem_wen         = 1'b0;
        mem_ren         = 1'b0;
        // no owner outside the response phases: drain stale beats
        mem_rdata_ready = 1'b1;
`ifdef ARB_RR_EN
        last_owner_d    = last_owner_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant_data) begin
                    load    = 1'b1;
                    ld_addr = Address;
`ifdef ARB_RR_EN
                    last_owner_d = OWN_DATA;
`endif
                    if (MemRead) begin
                        ld_type = REQ_READ;
                        state_d = S_D_RD;
                    end else begin
                        ld_type  = REQ_WRITE;
                        ld_wdata = Write_data;
                        ld_wstrb = Write_strb;
                        state_d  = S_D_WR;
                    end
                end else if (Inst_Req_Valid) begin
                    load    = 1'b1;
                    ld_addr = PC;
                    ld_type = REQ_READ;
                    state_d = S_I_REQ;
`ifdef ARB_RR_EN
                    last_owner_d = OWN_INST;
`endif
                end
            end
            S_I_REQ: begin
                mem_ren        = (req_type == REQ_READ);
                Inst_Req_Ready = mem_req_ready;
                if (mem_req_ready) state_d = S_I_RESP;
            end
            S_D_RD: begin
                mem_ren       = (req_type == REQ_READ);
                Mem_Req_Ready = mem_req_ready;
                if (mem_req_ready) state_d = S_D_RESP;
            end
            S_D_WR: begin
                mem_wen       = (req_type == REQ_WRITE);
                Mem_Req_Ready = mem_req_ready;
                if (mem_req_ready) state_d = S_IDLE;
            end
            S_I_RESP: begin
                Instruction     = mem_rdata;
                Inst_Valid      = mem_rdata_valid;
                mem_rdata_ready = Inst_Ready;
                if (mem_rdata_valid && Inst_Ready) state_d = S_IDLE;
            end
            S_D_RESP: begin
                Read_data       = mem_rdata;
                Read_data_Valid = mem_rdata_valid;
                mem_rdata_ready = Read_data_Ready;
                if (mem_rdata_valid && Read_data_Ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Inputs change 1ns after the rising
// edge and outputs are checked 1ns later, well clear of the next edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC;
    logic        Inst_Req_Valid;
    logic        Inst_Req_Ready;
    logic [31:0] Instruction;
    logic        Inst_Valid;
    logic        Inst_Ready;
    logic [31:0] Address;
    logic        MemWrite;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        MemRead;
    logic        Mem_Req_Ready;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_wen;
    logic        mem_ren;
    logic        mem_req_ready;
    logic [31:0] mem_rdata;
    logic        mem_rdata_valid;
    logic        mem_rdata_ready;

    int checks = 0;
    int errors = 0;
    logic first_inst;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .PC              (PC),
        .Inst_Req_Valid  (Inst_Req_Valid),
        .Inst_Req_Ready  (Inst_Req_Ready),
        .Instruction     (Instruction),
        .Inst_Valid      (Inst_Valid),
        .Inst_Ready      (Inst_Ready),
        .Address         (Address),
        .MemWrite        (MemWrite),
        .Write_data      (Write_data),
        .Write_strb      (Write_strb),
        .MemRead         (MemRead),
        .Mem_Req_Ready   (Mem_Req_Ready),
        .Read_data       (Read_data),
        .Read_data_Valid (Read_data_Valid),
        .Read_data_Ready (Read_data_Ready),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_wstrb       (mem_wstrb),
        .mem_wen         (mem_wen),
        .mem_ren         (mem_ren),
        .mem_req_ready   (mem_req_ready),
        .mem_rdata       (mem_rdata),
        .mem_rdata_valid (mem_rdata_valid),
        .mem_rdata_ready (mem_rdata_ready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // let combinational outputs settle after driving inputs
    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        PC = '0; Inst_Req_Valid = 0; Inst_Ready = 0;
        Address = '0; MemWrite = 0; Write_data = '0; Write_strb = '0; MemRead = 0;
        Read_data_Ready = 0; mem_req_ready = 0; mem_rdata = '0; mem_rdata_valid = 0;

        // ---- reset state
        cyc(); cyc(); settle();
        chk("rst_inst_req_ready", Inst_Req_Ready, 0);
        chk("rst_inst_valid", Inst_Valid, 0);
        chk("rst_mem_req_ready", Mem_Req_Ready, 0);
        chk("rst_rd_valid", Read_data_Valid, 0);
        chk("rst_wen", mem_wen, 0);
        chk("rst_ren", mem_ren, 0);
        chk("rst_rdata_ready", mem_rdata_ready, 1);
        cyc(); rst = 1'b0;

        // ---- 1. fetch only
        PC = 32'h100; Inst_Req_Valid = 1; settle();
        chk("t1_idle_ren", mem_ren, 0);
        cyc(); settle();                             // I_REQ, stalled
        chk("t1_ren", mem_ren, 1);
        chk("t1_addr", mem_addr, 32'h100);
        chk("t1_iready_wait", Inst_Req_Ready, 0);
        cyc(); settle();
        chk("t1_iready_wait2", Inst_Req_Ready, 0);
        cyc(); mem_req_ready = 1; settle();
        chk("t1_iready_pulse", Inst_Req_Ready, 1);
        chk("t1_mready_never", Mem_Req_Ready, 0);
        cyc(); Inst_Req_Valid = 0; mem_req_ready = 0; Inst_Ready = 1;
        mem_rdata = 32'h13; settle();                // I_RESP, no beat yet
        chk("t1_ivalid_early", Inst_Valid, 0);
        chk("t1_ren_resp", mem_ren, 0);
        cyc(); mem_rdata_valid = 1; settle();
        chk("t1_instr", Instruction, 32'h13);
        chk("t1_ivalid", Inst_Valid, 1);
        chk("t1_rdvalid_other", Read_data_Valid, 0);
        chk("t1_rdata_other", Read_data, 0);
        chk("t1_rready", mem_rdata_ready, 1);
        chk("t1_mready_never2", Mem_Req_Ready, 0);
        cyc(); mem_rdata_valid = 0; settle();        // IDLE
        chk("t1_ivalid_done", Inst_Valid, 0);

        // ---- 2. simultaneous read and fetch: data first
        MemRead = 1; Address = 32'h200; Inst_Req_Valid = 1; PC = 32'h104;
        cyc(); settle();
        chk("t2_addr_first", mem_addr, 32'h200);
        chk("t2_ren", mem_ren, 1);
        mem_req_ready = 1; settle();
        chk("t2_mready", Mem_Req_Ready, 1);
        chk("t2_iready_no", Inst_Req_Ready, 0);
        cyc(); MemRead = 0; mem_req_ready = 0;
        mem_rdata = 32'hCAFE0001; mem_rdata_valid = 1; Read_data_Ready = 1; settle();
        chk("t2_rdata", Read_data, 32'hCAFE0001);
        chk("t2_rdvalid", Read_data_Valid, 1);
        chk("t2_ivalid_other", Inst_Valid, 0);
        chk("t2_instr_other", Instruction, 0);
        chk("t2_no_fetch_yet", mem_ren, 0);
        cyc(); mem_rdata_valid = 0; settle();        // IDLE: grant cycle
        chk("t2_idle_ren", mem_ren, 0);
        cyc(); settle();
        chk("t2_fetch_addr", mem_addr, 32'h104);
        chk("t2_fetch_ren", mem_ren, 1);
        mem_req_ready = 1; settle();
        chk("t2_fetch_iready", Inst_Req_Ready, 1);
        cyc(); Inst_Req_Valid = 0; mem_req_ready = 0;
        mem_rdata = 32'h93; mem_rdata_valid = 1; settle();
        chk("t2_fetch_instr", Instruction, 32'h93);
        cyc(); mem_rdata_valid = 0;

        // ---- 3. store held under backpressure
        MemWrite = 1; Address = 32'h40; Write_data = 32'hDEADBEEF; Write_strb = 4'b0011;
        cyc();
        Address = 32'h999; Write_data = 32'h0; Write_strb = 4'hF; // captured copy must win
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("t3_wen", mem_wen, 1);
            chk("t3_ren", mem_ren, 0);
            chk("t3_addr", mem_addr, 32'h40);
            chk("t3_wdata", mem_wdata, 32'hDEADBEEF);
            chk("t3_wstrb", mem_wstrb, 4'b0011);
            chk("t3_mready_wait", Mem_Req_Ready, 0);
            cyc();
        end
        mem_req_ready = 1; settle();
        chk("t3_mready", Mem_Req_Ready, 1);
        cyc(); MemWrite = 0; mem_req_ready = 0;

        // ---- 4. back in IDLE at once; load with response backpressure
        MemRead = 1; Address = 32'h80; settle();
        chk("t3_idle_wen", mem_wen, 0);
        chk("t3_idle_rready", mem_rdata_ready, 1);
        cyc(); settle();
        chk("t4_addr", mem_addr, 32'h80);
        chk("t4_ren", mem_ren, 1);
        mem_req_ready = 1;
        cyc(); MemRead = 0; mem_req_ready = 0;
        mem_rdata = 32'h12345678; mem_rdata_valid = 1; Read_data_Ready = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t4_bp_rready", mem_rdata_ready, 0);
            chk("t4_bp_rdvalid", Read_data_Valid, 1);
            cyc();
        end
        Read_data_Ready = 1; settle();
        chk("t4_rready", mem_rdata_ready, 1);
        chk("t4_rdata", Read_data, 32'h12345678);
        cyc(); settle();                             // IDLE, beat still high
        chk("t4_once", Read_data_Valid, 0);
        chk("t4_drain", mem_rdata_ready, 1);
        mem_rdata_valid = 0;

        // ---- 6. both sides request right after a data transaction
`ifdef ARB_RR_EN
        first_inst = 1'b1;
`else
        first_inst = 1'b0;
`endif
        MemRead = 1; Address = 32'h400; Inst_Req_Valid = 1; PC = 32'h500;
        cyc(); settle();
        chk("t6_first_addr", mem_addr, first_inst ? 32'h500 : 32'h400);
        chk("t6_first_ren", mem_ren, 1);
        mem_req_ready = 1; settle();
        chk("t6_first_iready", Inst_Req_Ready, first_inst);
        chk("t6_first_mready", Mem_Req_Ready, !first_inst);
        cyc(); mem_req_ready = 0;
        if (first_inst) Inst_Req_Valid = 0; else MemRead = 0;
        mem_rdata = 32'h600; mem_rdata_valid = 1; Inst_Ready = 1; Read_data_Ready = 1; settle();
        chk("t6_first_ivalid", Inst_Valid, first_inst);
        chk("t6_first_rdvalid", Read_data_Valid, !first_inst);
        cyc(); mem_rdata_valid = 0;
        cyc(); settle();
        chk("t6_second_addr", mem_addr, first_inst ? 32'h400 : 32'h500);
        mem_req_ready = 1; settle();
        chk("t6_second_iready", Inst_Req_Ready, !first_inst);
        chk("t6_second_mready", Mem_Req_Ready, first_inst);
        cyc(); mem_req_ready = 0; MemRead = 0; Inst_Req_Valid = 0;
        mem_rdata = 32'h700; mem_rdata_valid = 1; settle();
        chk("t6_second_ivalid", Inst_Valid, !first_inst);
        chk("t6_second_rdvalid", Read_data_Valid, first_inst);
        cyc(); mem_rdata_valid = 0;

        // ---- read beats write when both asserted
        MemRead = 1; MemWrite = 1; Address = 32'h300; Write_data = 32'h55; Write_strb = 4'hF;
        cyc(); settle();
        chk("rw_ren", mem_ren, 1);
        chk("rw_wen", mem_wen, 0);
        chk("rw_addr", mem_addr, 32'h300);
        mem_req_ready = 1;
        cyc(); MemRead = 0; MemWrite = 0; mem_req_ready = 0;
        mem_rdata = 32'h301; mem_rdata_valid = 1; settle();
        chk("rw_rdata", Read_data, 32'h301);
        cyc(); mem_rdata_valid = 0;

        // ---- 5. reset while waiting in I_RESP
        Inst_Req_Valid = 1; PC = 32'h200;
        cyc(); mem_req_ready = 1;
        cyc(); Inst_Req_Valid = 0; mem_req_ready = 0; Inst_Ready = 0; settle();
        chk("t5_in_iresp", mem_rdata_ready, 0);
        rst = 1;
        cyc(); rst = 0; Inst_Ready = 1;
        mem_rdata = 32'hBAD; mem_rdata_valid = 1; settle();
        chk("t5_ivalid", Inst_Valid, 0);
        chk("t5_instr", Instruction, 0);
        chk("t5_rready", mem_rdata_ready, 1);
        chk("t5_rdvalid", Read_data_Valid, 0);
        chk("t5_ren", mem_ren, 0);
        cyc(); mem_rdata_valid = 0; settle();
        chk("t5_idle_ren", mem_ren, 0);
        chk("t5_idle_ivalid", Inst_Valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
